serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver at the far end of the multiplier's shift-register serial link. It takes the serial output of a shift register, one bit per qualified clock, and assembles a WIDTH-bit word.
- A bit counter and a small control FSM present the completed word with a ready/acknowledge handshake.
- It is used to capture product/operand words streamed out of the datapath registers for checking or storage.

Parameters:
- WIDTH, 16, word length in bits; legal range 2..32.
- MSB_FIRST, 1, bit order.
  - 1: incoming bits enter at bit 0 and shift toward bit WIDTH-1 (left shift; first bit ends in bit WIDTH-1).
  - 0: incoming bits enter at bit WIDTH-1 and shift toward bit 0 (right shift; first bit ends in bit 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a new word capture; clears word register and counter.
- sis  input  1  serial data in.
- bit_vld  input  1  sis is valid this cycle.
- word_ack  input  1  consumer accepts the completed word.
- Q  output  WIDTH  word register; partial contents during capture, final word when word_rdy=1.
- word_rdy  output  1  completed word held on Q.
- busy  output  1  capture in progress.
- bit_cnt  output  $clog2(WIDTH+1)  bits received in current word.
- overrun  output  1  sticky flag: bit_vld arrived while a word was pending.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, Q=0, bit_cnt=0, word_rdy=0, busy=0, overrun=0. Reset mid-capture discards the partial word.
- All other updates occur on the rising edge of clk.
- FSM states: IDLE, RECV, FULL.
  - busy=1 only in RECV.
  - word_rdy=1 only in FULL.
- IDLE:
  - start=1 -> RECV next cycle, with Q=0, bit_cnt=0, overrun=0.
  - bit_vld and word_ack are ignored.
- RECV:
  - bit_vld=1 -> shift sis into Q per MSB_FIRST; bit_cnt+1.
  - If the accepted bit is bit WIDTH (bit_cnt was WIDTH-1) -> FULL next cycle, with bit_cnt=WIDTH and Q holding the complete word.
  - word_rdy rises the cycle after the WIDTH-th accepted bit.
  - bit_vld=0 -> hold. Gaps of any length are allowed.
  - start=1 has priority over bit_vld: Q=0, bit_cnt=0, stay in RECV, and that cycle's bit is dropped.
- FULL:
  - Q and bit_cnt are frozen.
  - bit_vld=1 -> bit dropped and overrun set to 1 (sticky until next start or reset).
  - word_ack=1 -> IDLE next cycle; Q retains the word and bit_cnt is unchanged.
  - word_ack=1 and start=1 in the same cycle -> RECV with Q=0, bit_cnt=0, overrun=0.
  - start=1 alone -> RECV (word abandoned), with Q=0, bit_cnt=0, overrun=0.
- word_ack outside FULL is ignored.
- No combinational paths from inputs to outputs; all outputs are registered or decoded from the state register.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: ST_IDLE=2'b00, ST_RECV=2'b01, ST_FULL=2'b10.
  - The counter-width function.
- One sub-module is natural: shift_reg_sipo. It is a WIDTH-bit serial-in parallel-out register with a direction parameter, with inputs clr, shift_en and si and output Q. It uses the same asynchronous active-low reset.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, start, then 16 bits of 0xA5C3 MSB-first with bit_vld continuously high (MSB_FIRST=1):
  - word_rdy=1 exactly one cycle after the 16th bit.
  - Q=16'hA5C3, bit_cnt=16, busy=0.
  - word_ack returns state to IDLE with Q unchanged.
- MSB_FIRST=0 instance, bits of 0x8001 sent LSB-first:
  - Q=16'h8001.
  - Intermediate Q after 1 bit is 16'h8000.
- Same word as scenario 1 with random 0-5 cycle gaps in bit_vld:
  - identical final Q=16'hA5C3.
  - word_rdy never asserts before the 16th bit.
- In FULL, drive 3 bit_vld pulses before word_ack:
  - overrun=1 and Q unchanged.
  - Next start clears overrun to 0.
- start asserted after 7 bits, then a full 0x1234:
  - Q=16'h1234; no residue of the first 7 bits.
  - Simultaneous start+word_ack in FULL enters RECV with bit_cnt=0.
- rst pulsed low mid-capture (bit_cnt=9), asynchronously between clock edges:
  - all outputs zero immediately, state IDLE.
  - Subsequent bit_vld is ignored until start.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// serial_word_receiver_pkg: FSM state encodings and counter sizing shared by the
// serial word receiver and its shift register.
package serial_word_receiver_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RECV = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

    // Bits needed to count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_word_receiver_sipo.sv
// shift_reg_sipo: WIDTH-bit serial-in parallel-out register.
// MSB_FIRST=1 shifts left (first bit ends in the MSB), 0 shifts right.
module shift_reg_sipo #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             si,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            Q <= '0;
        else if (clr)
            Q <= '0;
        else if (shift_en)
            Q <= MSB_FIRST ? {Q[WIDTH-2:0], si} : {si, Q[WIDTH-1:1]};
    end

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles WIDTH serial bits into a word and hands it
// over with a word_rdy/word_ack handshake; overrun flags bits lost while full.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          sis,
    input  logic                          bit_vld,
    input  logic                          word_ack,
    output logic [WIDTH-1:0]              Q,
    output logic                          word_rdy,
    output logic                          busy,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
    output logic                          overrun
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       shift_en;

    // start wins over everything, so a bit arriving with start is dropped.
    assign shift_en = (state == ST_RECV) && !start && bit_vld;

    assign state_nxt = start ? ST_RECV
                     : (state == ST_RECV) ? ((bit_vld && bit_cnt == LAST) ? ST_FULL : ST_RECV)
                     : (state == ST_FULL) ? (word_ack ? ST_IDLE : ST_FULL)
                     : ST_IDLE;

    assign busy     = (state == ST_RECV);
    assign word_rdy = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= start ? '0 : shift_en ? bit_cnt + CW'(1) : bit_cnt;
            overrun <= start ? 1'b0 : ((state == ST_FULL) && bit_vld) ? 1'b1 : overrun;
        end
    end

    shift_reg_sipo #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sipo (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .shift_en(shift_en),
        .si      (sis),
        .Q       (Q)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed checks of both bit orders, gaps, overrun,
// restart and asynchronous reset.
module tb_serial_word_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0, sis0 = 1'b0, vld0 = 1'b0, ack0 = 1'b0;
    logic        start1 = 1'b0, sis1 = 1'b0, vld1 = 1'b0, ack1 = 1'b0;
    logic [15:0] q0, q1;
    logic        rdy0, rdy1, busy0, busy1, ov0, ov1;
    logic [4:0]  cnt0, cnt1;
    int          checks = 0;
    int          failures = 0;
    logic        early = 1'b0;
    logic [15:0] w;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(16), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .sis(sis0), .bit_vld(vld0),
        .word_ack(ack0), .Q(q0), .word_rdy(rdy0), .busy(busy0),
        .bit_cnt(cnt0), .overrun(ov0)
    );

    serial_word_receiver #(.WIDTH(16), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sis(sis1), .bit_vld(vld1),
        .word_ack(ack1), .Q(q1), .word_rdy(rdy1), .busy(busy1),
        .bit_cnt(cnt1), .overrun(ov1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle for gap cycles, then present one bit to u0; flags any early word_rdy.
    task automatic send0(input logic b, input int gap, input logic last);
        vld0 = 1'b0;
        repeat (gap) begin
            tick();
            if (rdy0) early = 1'b1;
        end
        sis0 = b;
        vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        if (!last && rdy0) early = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_q", q0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_rdy", rdy0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ov", ov0, 0);
        rst = 1'b1;
        tick();

        // Scenario 1: 0xA5C3 MSB-first, no gaps
        w = 16'hA5C3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s1_busy", busy0, 1);
        chk("s1_cnt0", cnt0, 0);
        for (int i = 15; i >= 0; i--) begin
            sis0 = w[i];
            vld0 = 1'b1;
            tick();
            if (i == 1) chk("s1_rdy_pre16", rdy0, 0);
        end
        vld0 = 1'b0;
        chk("s1_rdy", rdy0, 1);
        chk("s1_q", q0, 16'hA5C3);
        chk("s1_cnt", cnt0, 16);
        chk("s1_busy_full", busy0, 0);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("s1_ack_rdy", rdy0, 0);
        chk("s1_ack_busy", busy0, 0);
        chk("s1_ack_q", q0, 16'hA5C3);
        chk("s1_ack_cnt", cnt0, 16);
        tick();
        chk("s1_idle_rdy", rdy0, 0);

        // Scenario 2: MSB_FIRST=0, 0x8001 LSB-first
        w = 16'h8001;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sis1 = w[i];
            vld1 = 1'b1;
            tick();
            if (i == 0) chk("s2_q_1bit", q1, 16'h8000);
        end
        vld1 = 1'b0;
        chk("s2_q", q1, 16'h8001);
        chk("s2_rdy", rdy1, 1);
        chk("s2_cnt", cnt1, 16);

        // Scenario 3: same word with 0-5 cycle gaps
        w = 16'hA5C3;
        early = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 15; i >= 0; i--)
            send0(w[i], $urandom_range(0, 5), i == 0);
        chk("s3_early_rdy", early, 0);
        chk("s3_rdy", rdy0, 1);
        chk("s3_q", q0, 16'hA5C3);

        // Scenario 4: overrun while full
        for (int i = 0; i < 3; i++) begin
            sis0 = i[0];
            vld0 = 1'b1;
            tick();
        end
        vld0 = 1'b0;
        chk("s4_ov", ov0, 1);
        chk("s4_q", q0, 16'hA5C3);
        chk("s4_cnt", cnt0, 16);
        chk("s4_rdy", rdy0, 1);
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("s4_ack_rdy", rdy0, 0);
        chk("s4_ov_sticky", ov0, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s4_ov_clr", ov0, 0);

        // Scenario 5: restart after 7 bits, then 0x1234
        for (int i = 0; i < 7; i++) send0(1'b1, 0, 1'b0);
        chk("s5_cnt7", cnt0, 7);
        chk("s5_q7", q0, 16'h007F);
        start0 = 1'b1;
        sis0 = 1'b1;
        vld0 = 1'b1;
        tick();
        start0 = 1'b0;
        vld0 = 1'b0;
        chk("s5_restart_cnt", cnt0, 0);
        chk("s5_restart_q", q0, 0);
        w = 16'h1234;
        for (int i = 15; i >= 0; i--) send0(w[i], 0, 1'b1);
        chk("s5_q", q0, 16'h1234);
        chk("s5_rdy", rdy0, 1);
        start0 = 1'b1;
        ack0 = 1'b1;
        tick();
        start0 = 1'b0;
        ack0 = 1'b0;
        chk("s5_sa_busy", busy0, 1);
        chk("s5_sa_rdy", rdy0, 0);
        chk("s5_sa_cnt", cnt0, 0);
        chk("s5_sa_q", q0, 0);

        // Scenario 6: asynchronous reset mid-capture
        w = 16'hB6D5;
        for (int i = 15; i >= 7; i--) send0(w[i], 0, 1'b0);
        chk("s6_cnt9", cnt0, 9);
        chk("s6_q9", q0, 16'h016D);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_q", q0, 0);
        chk("s6_rst_cnt", cnt0, 0);
        chk("s6_rst_busy", busy0, 0);
        chk("s6_rst_rdy", rdy0, 0);
        chk("s6_rst_ov", ov0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sis0 = 1'b1;
            vld0 = 1'b1;
            tick();
        end
        vld0 = 1'b0;
        chk("s6_ign_busy", busy0, 0);
        chk("s6_ign_cnt", cnt0, 0);
        chk("s6_ign_q", q0, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        send0(1'b1, 0, 1'b0);
        chk("s6_post_q", q0, 16'h0001);
        chk("s6_post_cnt", cnt0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
